run_scan_arbiter: RTL and testbench

//   Shares one serial run-length detector (input det_x, clear det_clr, 2-bit Mealy code det_y)

---
 rtl/run_scan_arbiter.sv | 124 ++++++++++++
 tb/tb_run_scan_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/run_scan_arbiter.sv
// run_scan_arbiter - round-robin share of one serial run-length detector among NREQ requesters
module run_scan_arbiter #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            result,
    output logic [IDW-1:0]        result_id,
    output logic                  det_x,
    output logic                  det_clr,
    input  logic [1:0]            det_y
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

    state_t           state, state_nx;
    logic [IDW-1:0]   ptr, sel, sel_hi, sel_lo, id;
    logic             found, found_hi, found_lo;
    logic [WIDTH-1:0] sh, sel_word;
    logic [CW-1:0]    cnt;
    logic [1:0]       run_max, max_nx;
    logic             last_bit;

    // ptr holds the index searched first; requesters at or above it win over those below it
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                if (IDW'(j) >= ptr) begin
                    found_hi = 1'b1;
                    sel_hi   = IDW'(j);
                end else begin
                    found_lo = 1'b1;
                    sel_lo   = IDW'(j);
                end
            end
        end
        found = found_hi | found_lo;
        sel   = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        sel_word = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (IDW'(j) == sel) sel_word = data[j*WIDTH +: WIDTH];
        end
    end

    assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
    // det_y carries a code only on the closing 0 of a run
    assign max_nx   = (!det_x && (det_y > run_max)) ? det_y : run_max;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE);
        done     = (state == REPORT);
        det_clr  = (state != SHIFT);
        det_x    = (state == SHIFT) ? sh[0] : 1'b1;
        case (state)
            IDLE:    if (found) state_nx = CLEAR;
            CLEAR:   state_nx = SHIFT;
            SHIFT:   if (last_bit) state_nx = REPORT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            ptr       <= '0;
            id        <= '0;
            sh        <= '0;
            cnt       <= '0;
            run_max   <= '0;
            result    <= '0;
            result_id <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt <= NREQ'(1) << sel;
                        id  <= sel;
                        sh  <= sel_word;
                        ptr <= (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
                    end
                end
                CLEAR: begin
                    cnt     <= '0;
                    run_max <= '0;
                end
                SHIFT: begin
                    sh      <= sh >> 1;
                    cnt     <= cnt + CW'(1);
                    run_max <= max_nx;
                    if (last_bit) begin
                        result    <= max_nx;
                        result_id <= id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_run_scan_arbiter.sv
// tb/tb_run_scan_arbiter.sv - table, sequence and random checks of run_scan_arbiter with a detector model
module tb_run_scan_arbiter;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;
    localparam int IDW   = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  busy, done, det_x, det_clr;
    logic [1:0]            result, det_y;
    logic [IDW-1:0]        result_id;

    run_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt), .busy(busy), .done(done),
        .result(result), .result_id(result_id), .det_x(det_x), .det_clr(det_clr), .det_y(det_y)
    );

    always #5 clk = ~clk;

    // detector: counts ones since the last 0; the code on a 0 needs an earlier 0 since clear
    logic seen0 = 1'b0;
    int   run   = 0;
    assign det_y = (!det_x && seen0) ? ((run >= 3) ? 2'd3 : 2'(run)) : 2'd0;
    always @(posedge clk) begin
        if (det_clr) begin
            seen0 <= 1'b0;
            run   <= 0;
        end else if (!det_x) begin
            seen0 <= 1'b1;
            run   <= 0;
        end else if (run < 3) begin
            run <= run + 1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int mp    = 0;

    typedef struct {
        logic [7:0] w;
        logic [1:0] code;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // largest closed run: for each 0 with an earlier 0, count the ones directly below it
    function automatic logic [1:0] ref_code(input logic [7:0] w);
        int best, n, j;
        best = 0;
        for (int k = 1; k < 8; k++) begin
            if (w[k] == 1'b0) begin
                n = 0;
                j = k - 1;
                while (j >= 0 && w[j] == 1'b1) begin
                    n++;
                    j--;
                end
                if (j >= 0 && n > best) best = (n > 3) ? 3 : n;
            end
        end
        return 2'(best);
    endfunction

    function automatic int pick(input logic [1:0] rq);
        return rq[mp] ? mp : 1 - mp;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic follow(input int id, input logic [7:0] w, input int lat, input bit late,
                          input logic [7:0] ld1, input bit hold, input logic [1:0] exp_res);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == '0 && t < 8);
        check("gnt_latency", 32'(t), 32'(lat));
        check("gnt_onehot", 32'(gnt), 32'(1 << id));
        check("busy_clear", 32'(busy), 32'(1));
        check("det_clr_clear", 32'(det_clr), 32'(1));
        check("det_x_clear", 32'(det_x), 32'(1));
        if (!hold) begin
            req  = '0;
            data = 16'($urandom);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (late && k == 3) begin
                req        = 2'b10;
                data[15:8] = ld1;
            end
            check("det_clr_shift", 32'(det_clr), 32'(0));
            check("det_x_bit", 32'(det_x), 32'(w[k]));
            check("gnt_in_job", 32'(gnt), 32'(0));
            check("done_early", 32'(done), 32'(0));
        end
        @(negedge clk);
        check("done_pulse", 32'(done), 32'(1));
        check("result", 32'(result), 32'(exp_res));
        check("result_id", 32'(result_id), 32'(id));
        mp = (id + 1) % 2;
        @(negedge clk);
        check("done_off", 32'(done), 32'(0));
        check("busy_idle", 32'(busy), 32'(0));
    endtask

    task automatic do_job(input logic [1:0] rq, input logic [7:0] d0, input logic [7:0] d1);
        int id;
        logic [7:0] w;
        id = pick(rq);
        w  = (id == 1) ? d1 : d0;
        tick();
        req  = rq;
        data = {d1, d0};
        follow(id, w, 2, 1'b0, 8'h00, 1'b0, ref_code(w));
    endtask

    initial begin
        int t, dcount;
        tbl[0] = '{8'b0111_0110, 2'b11};
        tbl[1] = '{8'b0000_0010, 2'b01};
        tbl[2] = '{8'b0000_0110, 2'b10};
        tbl[3] = '{8'b1111_1110, 2'b00};
        tbl[4] = '{8'b0000_0000, 2'b00};
        tbl[5] = '{8'b1111_0001, 2'b00};

        rst  = 1'b0;
        req  = '0;
        data = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_det_x", 32'(det_x), 32'(1));
        check("rst_det_clr", 32'(det_clr), 32'(1));
        check("rst_result", 32'(result), 32'(0));
        check("rst_result_id", 32'(result_id), 32'(0));
        rst = 1'b1;
        mp  = 0;

        foreach (tbl[i]) begin
            tick();
            req  = 2'b01;
            data = {8'($urandom), tbl[i].w};
            follow(0, tbl[i].w, 2, 1'b0, 8'h00, 1'b0, tbl[i].code);
        end

        // contention from reset: requests held high alternate 0,1,0,1
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        mp  = 0;
        tick();
        req  = 2'b11;
        data = {8'b0000_0110, 8'b0000_0010};
        follow(0, 8'b0000_0010, 2, 1'b0, 8'h00, 1'b1, 2'b01);
        follow(1, 8'b0000_0110, 1, 1'b0, 8'h00, 1'b1, 2'b10);
        follow(0, 8'b0000_0010, 1, 1'b0, 8'h00, 1'b1, 2'b01);
        follow(1, 8'b0000_0110, 1, 1'b0, 8'h00, 1'b0, 2'b10);

        // late request from requester 1 while job 0 shifts
        tick();
        req  = 2'b01;
        data = {8'b1111_1111, 8'b0111_0110};
        follow(pick(2'b01), 8'b0111_0110, 2, 1'b1, 8'b0000_1110, 1'b0, 2'b11);
        follow(pick(2'b10), 8'b0000_1110, 1, 1'b0, 8'h00, 1'b0, 2'b11);

        // reset in the middle of SHIFT drops the job
        tick();
        req  = 2'b01;
        data = 16'h00F6;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (gnt == '0 && t < 8);
        check("rst_job_gnt", 32'(gnt), 32'(1));
        req = '0;
        repeat (4) @(negedge clk);
        check("mid_shift_busy", 32'(busy), 32'(1));
        rst = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'(0));
        check("async_det_clr", 32'(det_clr), 32'(1));
        check("async_det_x", 32'(det_x), 32'(1));
        check("async_result", 32'(result), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        mp  = 0;
        dcount = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("no_done_after_rst", 32'(dcount), 32'(0));
        check("result_after_rst", 32'(result), 32'(0));

        for (int i = 0; i < 40; i++) begin
            do_job(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
